txt_console: RTL and testbench
==============================

Name: txt_console

Overview:
- Upstream writer for the 40x24 text buffer consumed by the framebuffer/vdp path.
- Accepts a byte stream of ASCII characters over a valid/ready handshake and converts each byte to a screen code.
- Writes the code into text RAM at a hardware cursor, and handles newline, backspace, clear-screen and hardware scroll.
- Drives a write port plus a 1-cycle-latency read port on the text RAM; cell index = row*COLS + col, matching the framebuffer's linear layout.

Parameters:
- COLS, 40, characters per row
- ROWS, 24, rows per screen
- ADR_W, 10, text RAM address width (COLS*ROWS <= 2**ADR_W)
- BLANK, 8'hA0, screen code written for a cleared cell (normal space)

Ports:
- CLOCK_50  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- char_valid  in  1  upstream byte available
- char_data  in  8  ASCII byte
- char_ready  out  1  block accepts char_data this cycle
- wr_en  out  1  text RAM write strobe
- wr_adr  out  ADR_W  text RAM write address
- wr_data  out  8  text RAM write data
- rd_adr  out  ADR_W  text RAM read address
- rd_data  in  8  text RAM data for rd_adr, valid one cycle after rd_adr
- cursor_col  out  6  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- busy  out  1  clear or scroll in progress

Behaviour:
- Reset (async assert, all regs): state=CLEAR, wr_en=0, wr_adr=0, wr_data=0, rd_adr=0, char_ready=0, busy=1, cursor (0,0). On release, CLEAR runs.
- Reset asserted mid-operation aborts immediately; no partial write completes after assertion.
- States:
  - CLEAR: write BLANK to addresses 0..959, one per cycle (960 cycles), then set cursor (0,0) and go to IDLE.
  - IDLE: char_ready=1, busy=0. Handshake = char_valid & char_ready.
  - SCROLL_COPY: rd_adr steps 40..959; each cycle, write rd_data to the previous rd_adr-40. Takes 921 cycles.
  - SCROLL_FILL: write BLANK to 920..959 (40 cycles), then go to IDLE with cursor (23,0).
- char_ready is registered and is 0 in every state except IDLE. A byte presented while busy stays pending; upstream holds it.
- Printable handling (0x20..0x7F; 0x60..0x7F folded to upper case by subtracting 0x20):
  - Screen code = {1'b1, ascii[6:0]}, e.g. "H"->8'hC8, space->8'hA0.
  - The cycle after the handshake: wr_en=1 for exactly one cycle, wr_adr=row*40+col, wr_data=code.
  - The cursor advances on the same edge. At col 39 it wraps to col 0, row+1.
  - At (23,39) the write completes first, then the block enters SCROLL_COPY.
- 0x0D (CR): col=0, row+1. No RAM write. At row 23 it enters SCROLL_COPY.
- 0x08 (BS):
  - col>0: col-1, and write BLANK at the new position.
  - col==0 and row>0: move to (row-1, 39) and write BLANK there.
  - At (0,0): no write, cursor unchanged.
- 0x0C (FF): enter CLEAR. Cursor ends at (0,0).
- Other control bytes (0x00..0x1F) and 0x80..0xFF are consumed with no write and no cursor change.
- Arithmetic: the address is computed in ADR_W bits with no overflow because max 959 < 1024. Cursor counters saturate nowhere; they only change via the rules above.
- Throughput: one byte per cycle in IDLE, back-to-back, except where a byte triggers scroll or clear.

Optional Feature:
- Macro: TXT_CONSOLE_INVERSE_EN.
- Defined:
  - 0x0E selects inverse mode; 0x0F selects normal mode. Neither writes RAM or moves the cursor.
  - In inverse mode, printable screen code = {2'b00, ascii[5:0]}, e.g. "H"->8'h08.
  - BLANK and scroll fill are unaffected by mode. Reset and CLEAR return to normal mode.
- Undefined: 0x0E and 0x0F are ignored like other control bytes, and all codes are normal.

Decomposition:
- Package txt_pkg:
  - COLS, ROWS, CELLS=960, BLANK
  - control byte constants CH_BS, CH_CR, CH_FF, CH_SO, CH_SI
  - state enum {CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL}
- Sub-module txt_encode (combinational): ascii byte + inverse flag -> screen code + printable/control class.

Test Plan:
- Reset release -> busy=1 for 960 cycles; wr_adr covers 0..959 with wr_data=8'hA0; then char_ready=1 and cursor (0,0).
- "HI" back-to-back from (0,0) -> writes (0,8'hC8), (1,8'hC9) on consecutive cycles; cursor (0,2).
- Preload rows with distinct codes, cursor (23,39), send "Z" -> write (959,8'hDA), then busy 961 cycles. Afterwards, cell n holds the old cell n+40 for n<920, cells 920..959=8'hA0, cursor (23,0).
- BS at (0,0) -> no wr_en, cursor (0,0). BS at (5,0) -> write (199,8'hA0), cursor (4,39).
- Reset asserted at cycle 300 of SCROLL_COPY -> wr_en=0 in the same cycle; after release a full CLEAR runs.
- With TXT_CONSOLE_INVERSE_EN: 0x0E,"H",0x0F,"H" -> writes 8'h08 then 8'hC8 at consecutive addresses; cursor advances by 2 only.

Source files
------------

// File: rtl/txt_pkg.sv
// Shared constants, control-byte codes and type definitions for the text console writer.
package txt_pkg;

    localparam int unsigned COLS  = 40;
    localparam int unsigned ROWS  = 24;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam logic [7:0]  BLANK = 8'hA0;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SO = 8'h0E;
    localparam logic [7:0] CH_SI = 8'h0F;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL_COPY,
        SCROLL_FILL
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_PRINT,
        CLS_BS,
        CLS_CR,
        CLS_FF,
        CLS_SO,
        CLS_SI
    } char_cls_e;

endpackage

// File: rtl/txt_encode.sv
// Combinational ASCII classifier and screen-code encoder for the text console.
module txt_encode
    import txt_pkg::*;
(
    input  logic [7:0] ascii,
    input  logic       inverse,
    output logic [7:0] code,
    output char_cls_e  cls
);

    logic [6:0] folded;

    always_comb begin
        // 0x60..0x7F fold onto upper case
        folded = ascii[6:0] - ((ascii[6:5] == 2'b11) ? 7'h20 : 7'h00);
        code   = inverse ? {2'b00, folded[5:0]} : {1'b1, folded};
        cls    = CLS_NONE;
        if (!ascii[7] && (ascii[6:5] != 2'b00)) begin
            cls = CLS_PRINT;
        end else begin
            unique case (ascii)
                CH_BS:   cls = CLS_BS;
                CH_CR:   cls = CLS_CR;
                CH_FF:   cls = CLS_FF;
                CH_SO:   cls = CLS_SO;
                CH_SI:   cls = CLS_SI;
                default: cls = CLS_NONE;
            endcase
        end
    end

endmodule

// File: rtl/txt_console.sv
// Byte-stream text console writer: cursor, newline, backspace, clear and hardware scroll.
// Optional inverse-video mode via SO/SI is enabled by defining TXT_CONSOLE_INVERSE_EN.
module txt_console #(
    parameter int unsigned COLS  = txt_pkg::COLS,
    parameter int unsigned ROWS  = txt_pkg::ROWS,
    parameter int unsigned ADR_W = 10,
    parameter logic [7:0]  BLANK = txt_pkg::BLANK
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic             wr_en,
    output logic [ADR_W-1:0] wr_adr,
    output logic [7:0]       wr_data,
    output logic [ADR_W-1:0] rd_adr,
    input  logic [7:0]       rd_data,
    output logic [5:0]       cursor_col,
    output logic [4:0]       cursor_row,
    output logic             busy
);
    import txt_pkg::*;

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(COLS * ROWS - 1);
    localparam logic [ADR_W-1:0] FILL_ADR = ADR_W'(COLS * ROWS - COLS);
    localparam logic [ADR_W-1:0] COLS_ADR = ADR_W'(COLS);
    localparam logic [5:0]       LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]       LAST_ROW = 5'(ROWS - 1);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] cnt_q, cnt_d;
    logic [ADR_W-1:0] rd_adr_q, rd_adr_d;
    logic [ADR_W-1:0] prev_q, prev_d;
    logic             prev_v_q, prev_v_d;
    logic             wr_en_q, wr_en_d;
    logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [5:0]       col_q, col_d;
    logic [4:0]       row_q, row_d;
    logic             go_scroll;

`ifdef TXT_CONSOLE_INVERSE_EN
    logic inv_q, inv_d;
`else
    logic inv_q;
    assign inv_q = 1'b0;
`endif

    logic [7:0]       code;
    char_cls_e        cls;
    logic [ADR_W-1:0] cur_adr;

    assign cur_adr = ADR_W'(row_q) * COLS_ADR + ADR_W'(col_q);

    txt_encode u_encode (
        .ascii   (char_data),
        .inverse (inv_q),
        .code    (code),
        .cls     (cls)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_adr_d  = rd_adr_q;
        prev_d    = prev_q;
        prev_v_d  = prev_v_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        col_d     = col_q;
        row_d     = row_q;
        go_scroll = 1'b0;
`ifdef TXT_CONSOLE_INVERSE_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_adr_d  = cnt_q;
                wr_data_d = BLANK;
                cnt_d     = cnt_q + 1'b1;
`ifdef TXT_CONSOLE_INVERSE_EN
                inv_d     = 1'b0;
`endif
                if (cnt_q == LAST_ADR) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            IDLE: begin
                if (char_valid && ready_q) begin
                    unique case (cls)
                        CLS_PRINT: begin
                            wr_en_d   = 1'b1;
                            wr_adr_d  = cur_adr;
                            wr_data_d = code;
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                if (row_q == LAST_ROW) go_scroll = 1'b1;
                                else row_d = row_q + 5'd1;
                            end else begin
                                col_d = col_q + 6'd1;
                            end
                        end
                        CLS_CR: begin
                            col_d = '0;
                            if (row_q == LAST_ROW) go_scroll = 1'b1;
                            else row_d = row_q + 5'd1;
                        end
                        CLS_BS: begin
                            // Both cases land on the cell just before the cursor.
                            if (col_q != 6'd0 || row_q != 5'd0) begin
                                wr_en_d   = 1'b1;
                                wr_adr_d  = cur_adr - 1'b1;
                                wr_data_d = BLANK;
                                if (col_q != 6'd0) begin
                                    col_d = col_q - 6'd1;
                                end else begin
                                    col_d = LAST_COL;
                                    row_d = row_q - 5'd1;
                                end
                            end
                        end
                        CLS_FF: begin
                            state_d = CLEAR;
                            cnt_d   = '0;
                            ready_d = 1'b0;
                            busy_d  = 1'b1;
                            col_d   = '0;
                            row_d   = '0;
                        end
`ifdef TXT_CONSOLE_INVERSE_EN
                        CLS_SO: inv_d = 1'b1;
                        CLS_SI: inv_d = 1'b0;
`endif
                        default: ;
                    endcase
                end
                if (go_scroll) begin
                    state_d  = SCROLL_COPY;
                    rd_adr_d = COLS_ADR;
                    prev_v_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SCROLL_COPY: begin
                // Read runs one cycle ahead of the write it feeds.
                rd_adr_d = (rd_adr_q == LAST_ADR) ? rd_adr_q : rd_adr_q + 1'b1;
                prev_d   = rd_adr_q;
                prev_v_d = 1'b1;
                if (prev_v_q) begin
                    wr_en_d   = 1'b1;
                    wr_adr_d  = prev_q - COLS_ADR;
                    wr_data_d = rd_data;
                    if (prev_q == LAST_ADR) begin
                        state_d  = SCROLL_FILL;
                        cnt_d    = FILL_ADR;
                        prev_v_d = 1'b0;
                    end
                end
            end
            SCROLL_FILL: begin
                wr_en_d   = 1'b1;
                wr_adr_d  = cnt_q;
                wr_data_d = BLANK;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADR) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            rd_adr_q  <= '0;
            prev_q    <= '0;
            prev_v_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
`ifdef TXT_CONSOLE_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_adr_q  <= rd_adr_d;
            prev_q    <= prev_d;
            prev_v_q  <= prev_v_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            col_q     <= col_d;
            row_q     <= row_d;
`ifdef TXT_CONSOLE_INVERSE_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign char_ready = ready_q;
    assign wr_en      = wr_en_q;
    assign wr_adr     = wr_adr_q;
    assign wr_data    = wr_data_q;
    assign rd_adr     = rd_adr_q;
    assign busy       = busy_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_txt_console.sv
// Scoreboard bench for txt_console with a behavioural 1-cycle-latency text RAM.
module tb_txt_console;

    localparam int COLS  = 40;
    localparam int CELLS = 960;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data  = 8'h00;
    logic       char_ready;
    logic       wr_en;
    logic [9:0] wr_adr;
    logic [7:0] wr_data;
    logic [9:0] rd_adr;
    logic [7:0] rd_data;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:1023];
    logic [7:0]  exp_mem [0:CELLS-1];
    logic [17:0] sb_q [$];
    logic [17:0] mon_exp;
    logic        sb_on = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    txt_console dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_adr     (wr_adr),
        .wr_data    (wr_data),
        .rd_adr     (rd_adr),
        .rd_data    (rd_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_adr] <= wr_data;
        rd_data <= mem[rd_adr];
    end

    // Scoreboard: every observed RAM write is matched against the next expected one.
    always @(negedge CLOCK_50) begin
        if (sb_on && wr_en) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got adr=%0d data=%h, required no write",
                         wr_adr, wr_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({wr_adr, wr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL wr_match: got adr=%0d data=%h, required adr=%0d data=%h",
                             wr_adr, wr_data, mon_exp[17:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void sb_push(input int adr, input logic [7:0] d);
        logic [9:0] a;
        a = 10'(adr);
        sb_q.push_back({a, d});
        exp_mem[adr] = d;
    endfunction

    function automatic logic [7:0] scr(input logic [7:0] b, input logic inv);
        logic [7:0] f;
        f = (b >= 8'h60) ? b - 8'h20 : b;
        return inv ? {2'b00, f[5:0]} : {1'b1, f[6:0]};
    endfunction

    task automatic drive(input logic [7:0] b);
        char_valid = 1'b1;
        char_data  = b;
        @(negedge CLOCK_50);
        char_valid = 1'b0;
    endtask

    task automatic test_reset;
        int busy_cnt;
        int cyc;
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (wr_en !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got wr_en=%b ready=%b busy=%b, required 0 0 1",
                     wr_en, char_ready, busy);
        end
        checks++;
        if (wr_adr !== 10'd0 || wr_data !== 8'h00 || rd_adr !== 10'd0) begin
            errors++;
            $display("FAIL reset_bus: got wr_adr=%0d wr_data=%h rd_adr=%0d, required 0 00 0",
                     wr_adr, wr_data, rd_adr);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col);
        end
        for (int i = 0; i < CELLS; i++) sb_push(i, 8'hA0);
        sb_on = 1'b1;
        reset = 1'b1;
        busy_cnt = 0;
        cyc = 0;
        while (!char_ready && cyc < 2000) begin
            if (busy) busy_cnt++;
            @(negedge CLOCK_50);
            cyc++;
        end
        #1;
        checks++;
        if (!char_ready) begin
            errors++;
            $display("FAIL reset_clear_timeout: got ready=0 after %0d cycles, required 1", cyc);
        end
        checks++;
        if (busy_cnt != 960) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d cycles, required 960", busy_cnt);
        end
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_done: got %0d writes missing busy=%b, required 0 0",
                     sb_q.size(), busy);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL reset_end_cursor: got (%0d,%0d), required (0,0)",
                     cursor_row, cursor_col);
        end
    endtask

    task automatic test_back_to_back;
        sb_push(0, 8'hC8);
        sb_push(1, 8'hC9);
        drive("H");
        #1;
        checks++;
        if (sb_q.size() != 1) begin
            errors++;
            $display("FAIL hi_first: got %0d pending, required 1", sb_q.size());
        end
        drive("I");
        #1;
        checks++;
        if (sb_q.size() != 0 || char_ready !== 1'b1) begin
            errors++;
            $display("FAIL hi_second: got %0d pending ready=%b, required 0 1",
                     sb_q.size(), char_ready);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd2) begin
            errors++;
            $display("FAIL hi_cursor: got (%0d,%0d), required (0,2)", cursor_row, cursor_col);
        end
    endtask

    task automatic test_fold;
        logic [7:0] bytes [4];
        logic [7:0] codes [4];
        bytes = '{8'h68, 8'h7F, 8'h20, 8'h40};
        codes = '{8'hC8, 8'hDF, 8'hA0, 8'hC0};
        for (int i = 0; i < 4; i++) sb_push(2 + i, codes[i]);
        for (int i = 0; i < 4; i++) drive(bytes[i]);
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_row !== 5'd0 || cursor_col !== 6'd6) begin
            errors++;
            $display("FAIL fold: got %0d pending cursor (%0d,%0d), required 0 (0,6)",
                     sb_q.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_ignore;
`ifdef TXT_CONSOLE_INVERSE_EN
        logic [7:0] bytes [4];
        bytes = '{8'h00, 8'h1B, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) drive(bytes[i]);
`else
        logic [7:0] bytes [6];
        bytes = '{8'h00, 8'h1B, 8'h80, 8'hFF, 8'h0E, 8'h0F};
        for (int i = 0; i < 6; i++) drive(bytes[i]);
`endif
        #1;
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd6 || char_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_cursor: got (%0d,%0d) ready=%b, required (0,6) 1",
                     cursor_row, cursor_col, char_ready);
        end
        sb_push(6, 8'hC8);
        drive("H");
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_col !== 6'd7) begin
            errors++;
            $display("FAIL ignore_then_h: got %0d pending col=%0d, required 0 7",
                     sb_q.size(), cursor_col);
        end
    endtask

    task automatic test_clear;
        int cyc;
        for (int i = 0; i < CELLS; i++) sb_push(i, 8'hA0);
        drive(8'h0C);
        #1;
        checks++;
        if (char_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ff_start: got ready=%b busy=%b, required 0 1", char_ready, busy);
        end
        cyc = 0;
        while (!char_ready && cyc < 2000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        #1;
        checks++;
        if (!char_ready || sb_q.size() != 0) begin
            errors++;
            $display("FAIL ff_done: got ready=%b pending=%0d, required 1 0",
                     char_ready, sb_q.size());
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL ff_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col);
        end
    endtask

    task automatic test_backspace;
        drive(8'h08);
        #1;
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL bs_origin: got (%0d,%0d), required (0,0)", cursor_row, cursor_col);
        end
        for (int i = 0; i < 5; i++) drive(8'h0D);
        #1;
        checks++;
        if (cursor_row !== 5'd5 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL cr_cursor: got (%0d,%0d), required (5,0)", cursor_row, cursor_col);
        end
        sb_push(199, 8'hA0);
        drive(8'h08);
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_row !== 5'd4 || cursor_col !== 6'd39) begin
            errors++;
            $display("FAIL bs_wrap: got %0d pending (%0d,%0d), required 0 (4,39)",
                     sb_q.size(), cursor_row, cursor_col);
        end
        sb_push(200, 8'hC1);
        sb_push(200, 8'hA0);
        drive(8'h0D);
        drive("A");
        drive(8'h08);
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_row !== 5'd5 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL bs_col: got %0d pending (%0d,%0d), required 0 (5,0)",
                     sb_q.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_scroll;
        logic [7:0] b;
        int busy_cnt;
        int cyc;
        for (int i = 0; i < 759; i++) begin
            b = 8'h21 + 8'(i % 94);
            sb_push(200 + i, scr(b, 1'b0));
            drive(b);
        end
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_row !== 5'd23 || cursor_col !== 6'd39) begin
            errors++;
            $display("FAIL preload: got %0d pending (%0d,%0d), required 0 (23,39)",
                     sb_q.size(), cursor_row, cursor_col);
        end
        sb_push(959, 8'hDA);
        for (int n = 0; n < CELLS - COLS; n++) sb_push(n, exp_mem[n + COLS]);
        for (int n = CELLS - COLS; n < CELLS; n++) sb_push(n, 8'hA0);
        drive("Z");
        busy_cnt = 0;
        cyc = 0;
        while (!char_ready && cyc < 3000) begin
            if (busy) busy_cnt++;
            @(negedge CLOCK_50);
            cyc++;
        end
        #1;
        checks++;
        if (!char_ready || sb_q.size() != 0) begin
            errors++;
            $display("FAIL scroll_done: got ready=%b pending=%0d, required 1 0",
                     char_ready, sb_q.size());
        end
        checks++;
        if (busy_cnt != 961) begin
            errors++;
            $display("FAIL scroll_busy_len: got %0d cycles, required 961", busy_cnt);
        end
        checks++;
        if (cursor_row !== 5'd23 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL scroll_cursor: got (%0d,%0d), required (23,0)",
                     cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_mid_scroll;
        int cyc;
        sb_on = 1'b0;
        drive(8'h0D);
        repeat (299) @(negedge CLOCK_50);
        checks++;
        if (wr_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL copy_active: got wr_en=%b busy=%b, required 1 1", wr_en, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort: got wr_en=%b ready=%b busy=%b, required 0 0 1",
                     wr_en, char_ready, busy);
        end
        @(negedge CLOCK_50);
        sb_q.delete();
        for (int i = 0; i < CELLS; i++) sb_push(i, 8'hA0);
        sb_on = 1'b1;
        reset = 1'b1;
        cyc = 0;
        while (!char_ready && cyc < 2000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        #1;
        checks++;
        if (!char_ready || sb_q.size() != 0 || cyc != 960) begin
            errors++;
            $display("FAIL abort_clear: got ready=%b pending=%0d cycles=%0d, required 1 0 960",
                     char_ready, sb_q.size(), cyc);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL abort_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col);
        end
    endtask

`ifdef TXT_CONSOLE_INVERSE_EN
    task automatic test_inverse;
        sb_push(0, 8'h08);
        sb_push(1, 8'hC8);
        drive(8'h0E);
        drive("H");
        drive(8'h0F);
        drive("H");
        #1;
        checks++;
        if (sb_q.size() != 0 || cursor_row !== 5'd0 || cursor_col !== 6'd2) begin
            errors++;
            $display("FAIL inverse: got %0d pending (%0d,%0d), required 0 (0,2)",
                     sb_q.size(), cursor_row, cursor_col);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_back_to_back;
        test_fold;
        test_ignore;
        test_clear;
        test_backspace;
        test_scroll;
        test_reset_mid_scroll;
`ifdef TXT_CONSOLE_INVERSE_EN
        test_inverse;
`endif
        repeat (3) @(negedge CLOCK_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
